// File: rtl/pcs_pkg.sv
// Shared PCS definitions for 64b/66b block handling.
// Provides the sync-header encodings, the block-sync lock state enum and the
// default window limits used by the RX block synchroniser and TX-side benches.
package pcs_pkg;

  localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
  localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;

  localparam int unsigned SH_CNT_MAX   = 64;
  localparam int unsigned SH_INVLD_MAX = 16;

  typedef enum logic [1:0] {
    LOCK_INIT,
    TEST_SH,
    SLIP,
    SLIP_WAIT
  } block_sync_state_t;

  // Only 01 (data) and 10 (control) are legal 64b/66b sync headers.
  function automatic logic sync_hdr_ok(input logic [1:0] hdr);
    return (hdr == SYNC_HDR_DATA) || (hdr == SYNC_HDR_CTRL);
  endfunction

endpackage

// File: rtl/pcs_rx_block_sync.sv
// 64b/66b RX block synchroniser with lock state machine.
// Validates sync headers from the RX gearbox, requests bit slips until block
// boundaries align, reports block lock, and forwards payload/header one cycle
// later qualified by lock.
// Ports:
//   i_rx_clk       RX user clock
//   i_rx_reset_n   asynchronous active-low reset
//   i_data/i_hdr   block payload and sync header from the gearbox
//   i_data_valid   beat qualifier (low while the gearbox stalls)
//   o_data/o_hdr   registered payload/header, captured on valid beats
//   o_data_valid   registered i_data_valid AND block lock
//   o_bitslip      single-cycle slip request to the gearbox
//   o_block_lock   block lock status
module pcs_rx_block_sync
  import pcs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned HDR_WIDTH    = 2,
  parameter int unsigned SH_CNT_MAX   = pcs_pkg::SH_CNT_MAX,
  parameter int unsigned SH_INVLD_MAX = pcs_pkg::SH_INVLD_MAX,
  parameter int unsigned SLIP_WAIT    = 32
) (
  input  logic                  i_rx_clk,
  input  logic                  i_rx_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [HDR_WIDTH-1:0]  i_hdr,
  input  logic                  i_data_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [HDR_WIDTH-1:0]  o_hdr,
  output logic                  o_data_valid,
  output logic                  o_bitslip,
  output logic                  o_block_lock
);

  localparam int unsigned CNT_W  = 7;
  localparam int unsigned INV_W  = 5;
  localparam int unsigned WAIT_W = 6;

  block_sync_state_t state;
  logic [CNT_W-1:0]  sh_cnt;
  logic [INV_W-1:0]  sh_invld_cnt;
  logic [WAIT_W-1:0] slip_wait_cnt;

  logic              hdr_bad;
  logic [CNT_W-1:0]  sh_cnt_inc;
  logic [INV_W-1:0]  sh_invld_inc;
  logic [WAIT_W-1:0] slip_wait_inc;
  logic              slip_hit;
  logic              window_end;

  // Post-increment counter values; decisions on a beat use these.
  always_comb begin
    hdr_bad       = !sync_hdr_ok(i_hdr);
    sh_cnt_inc    = sh_cnt + CNT_W'(1);
    sh_invld_inc  = sh_invld_cnt + INV_W'(hdr_bad);
    slip_wait_inc = slip_wait_cnt + WAIT_W'(1);
    slip_hit      = (!o_block_lock && hdr_bad) ||
                    (o_block_lock && (sh_invld_inc == INV_W'(SH_INVLD_MAX)));
    window_end    = (sh_cnt_inc == CNT_W'(SH_CNT_MAX));
  end

  // Lock state machine with its counters, lock flag and slip pulse.
  // The enum literal SLIP_WAIT is shadowed by the parameter of the same name,
  // so state references use the package scope.
  always_ff @(posedge i_rx_clk or negedge i_rx_reset_n) begin
    if (!i_rx_reset_n) begin
      state         <= LOCK_INIT;
      sh_cnt        <= '0;
      sh_invld_cnt  <= '0;
      slip_wait_cnt <= '0;
      o_bitslip     <= 1'b0;
      o_block_lock  <= 1'b0;
    end else begin
      o_bitslip <= 1'b0;
      case (state)
        LOCK_INIT: begin
          sh_cnt        <= '0;
          sh_invld_cnt  <= '0;
          slip_wait_cnt <= '0;
          o_block_lock  <= 1'b0;
          state         <= TEST_SH;
        end
        TEST_SH: begin
          if (i_data_valid) begin
            if (slip_hit) begin
              // Slip/unlock wins over a coincident window end.
              o_block_lock <= 1'b0;
              o_bitslip    <= 1'b1;
              sh_cnt       <= '0;
              sh_invld_cnt <= '0;
              state        <= SLIP;
            end else if (window_end) begin
              // Only a clean window can establish lock; a held lock survives
              // windows with fewer than SH_INVLD_MAX bad headers.
              if (sh_invld_inc == '0) begin
                o_block_lock <= 1'b1;
              end
              sh_cnt       <= '0;
              sh_invld_cnt <= '0;
            end else begin
              sh_cnt       <= sh_cnt_inc;
              sh_invld_cnt <= sh_invld_inc;
            end
          end
        end
        SLIP: begin
          sh_cnt        <= '0;
          sh_invld_cnt  <= '0;
          slip_wait_cnt <= '0;
          o_block_lock  <= 1'b0;
          state         <= pcs_pkg::SLIP_WAIT;
        end
        pcs_pkg::SLIP_WAIT: begin
          // Headers are meaningless while the gearbox realigns.
          if (i_data_valid) begin
            if (slip_wait_inc == WAIT_W'(SLIP_WAIT)) begin
              slip_wait_cnt <= '0;
              state         <= TEST_SH;
            end else begin
              slip_wait_cnt <= slip_wait_inc;
            end
          end
        end
        default: state <= LOCK_INIT;
      endcase
    end
  end

  // Datapath: capture on valid beats, qualify with the lock in effect now.
  always_ff @(posedge i_rx_clk or negedge i_rx_reset_n) begin
    if (!i_rx_reset_n) begin
      o_data       <= '0;
      o_hdr        <= '0;
      o_data_valid <= 1'b0;
    end else begin
      o_data_valid <= i_data_valid & o_block_lock;
      if (i_data_valid) begin
        o_data <= i_data;
        o_hdr  <= i_hdr;
      end
    end
  end

endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// Scoreboard bench for pcs_rx_block_sync: a driver steps a behavioural lock
// model per clock and queues the expected outputs; a monitor compares them.
module tb_pcs_rx_block_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] i_data;
  logic [1:0]  i_hdr;
  logic        i_data_valid;
  logic [63:0] o_data;
  logic [1:0]  o_hdr;
  logic        o_data_valid;
  logic        o_bitslip;
  logic        o_block_lock;

  pcs_rx_block_sync dut (
    .i_rx_clk    (clk),
    .i_rx_reset_n(rst_n),
    .i_data      (i_data),
    .i_hdr       (i_hdr),
    .i_data_valid(i_data_valid),
    .o_data      (o_data),
    .o_hdr       (o_hdr),
    .o_data_valid(o_data_valid),
    .o_bitslip   (o_bitslip),
    .o_block_lock(o_block_lock)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  hdr;
    logic        dv;
    logic        slip;
    logic        lock;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model: window position, bad count, beats left to ignore.
  int          m_w, m_bad, m_ignore;
  bit          m_locked, m_init, m_slip_pend;
  logic [63:0] m_data;
  logic [1:0]  m_hdr;

  task automatic model_reset();
    m_w = 0; m_bad = 0; m_ignore = 0;
    m_locked = 0; m_init = 1; m_slip_pend = 0;
    m_data = '0; m_hdr = '0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] h, input logic [63:0] d);
    bit was_locked;
    bit slip;
    bit bad;
    obs_t e;
    was_locked = m_locked;
    slip = 0;
    if (m_init) begin
      m_init = 0;
    end else if (m_slip_pend) begin
      m_slip_pend = 0;
      m_ignore = 32;
    end else if (v) begin
      if (m_ignore > 0) begin
        m_ignore--;
      end else begin
        bad = !(h == 2'b01 || h == 2'b10);
        m_w++;
        if (bad) m_bad++;
        if ((!m_locked && bad) || (m_locked && m_bad >= 16)) begin
          m_locked = 0; slip = 1; m_slip_pend = 1; m_w = 0; m_bad = 0;
        end else if (m_w == 64) begin
          if (m_bad == 0) m_locked = 1;
          m_w = 0; m_bad = 0;
        end
      end
    end
    if (v) begin
      m_data = d;
      m_hdr = h;
    end
    e.data = m_data;
    e.hdr  = m_hdr;
    e.dv   = v && was_locked;
    e.slip = slip;
    e.lock = m_locked;
    exp_q.push_back(e);
  endtask

  // Called at a negedge: drive, clock, predict, return to the next negedge.
  task automatic beat(input bit v, input logic [1:0] h, input logic [63:0] d);
    i_data_valid = v;
    i_hdr = h;
    i_data = d;
    @(posedge clk);
    if (rst_n) model_step(v, h, d);
    @(negedge clk);
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic good_beats(input int n);
    for (int i = 0; i < n; i++) beat(1, good_hdr(), rnd64());
  endtask

  // One 64-beat window with nbad invalid headers at random positions.
  task automatic window_with_bad(input int nbad);
    bit badpos[64];
    int placed;
    int p;
    for (int i = 0; i < 64; i++) badpos[i] = 0;
    placed = 0;
    while (placed < nbad) begin
      p = $urandom_range(0, 63);
      if (!badpos[p]) begin
        badpos[p] = 1;
        placed++;
      end
    end
    for (int i = 0; i < 64; i++) beat(1, badpos[i] ? bad_hdr() : good_hdr(), rnd64());
  endtask

  // Asynchronous reset asserted between clock edges; state cleared immediately.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    i_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // Monitor: zero outputs while in reset, scoreboard pops otherwise.
  obs_t exp_e;
  obs_t act_e;
  always begin
    @(posedge clk or negedge rst_n);
    #1;
    act_e = '{o_data, o_hdr, o_data_valid, o_bitslip, o_block_lock};
    if (!rst_n) begin
      vectors++;
      if (act_e != '0) begin
        miscompares++;
        $display("FAIL reset_outputs t=%0t actual=%h required=0", $time, act_e);
      end
    end else if (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      vectors++;
      if (act_e !== exp_e) begin
        miscompares++;
        $display("FAIL cycle t=%0t actual data=%h hdr=%b dv=%b slip=%b lock=%b required data=%h hdr=%b dv=%b slip=%b lock=%b",
                 $time, act_e.data, act_e.hdr, act_e.dv, act_e.slip, act_e.lock,
                 exp_e.data, exp_e.hdr, exp_e.dv, exp_e.slip, exp_e.lock);
      end
    end
  end

  int bad_rate;

  initial begin
    rst_n = 1'b0;
    i_data_valid = 1'b0;
    i_hdr = 2'b00;
    i_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Initial lock after 64 clean headers, then an observed locked beat.
    beat(0, 2'b00, '0);
    good_beats(64);
    // Locked windows: 15 bad keeps lock, clean window, 16 bad unlocks + slips.
    window_with_bad(15);
    good_beats(64);
    window_with_bad(16);
    good_beats(120);

    // Known payload while locked.
    beat(1, 2'b10, 64'hDEADBEEF_CAFEF00D);
    beat(0, 2'b01, rnd64());

    // Unlocked slip on beat 10, then 33 ignored beats full of bad headers.
    async_reset();
    beat(0, 2'b00, '0);
    good_beats(9);
    beat(1, 2'b00, rnd64());
    for (int i = 0; i < 33; i++) beat(1, 2'b11, rnd64());
    good_beats(67);

    // Valid toggling every cycle: lock needs 64 valid beats over 128 cycles.
    async_reset();
    beat(0, 2'b00, '0);
    for (int i = 0; i < 140; i++) beat(i % 2 == 0, good_hdr(), rnd64());

    // Reset after 40 good headers; lock must need a fresh 64.
    async_reset();
    beat(0, 2'b00, '0);
    good_beats(40);
    async_reset();
    beat(1, 2'b10, 64'hDEADBEEF_CAFEF00D);
    good_beats(70);

    // Known payload while unlocked.
    async_reset();
    beat(0, 2'b00, '0);
    beat(1, 2'b10, 64'hDEADBEEF_CAFEF00D);
    beat(0, 2'b01, rnd64());

    // Randomised soak with changing bad-header density and stalls.
    bad_rate = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       bad_rate = 0;
          1:       bad_rate = 2;
          default: bad_rate = 40;
        endcase
      end
      beat($urandom_range(0, 99) < 85,
           ($urandom_range(0, 99) < bad_rate) ? bad_hdr() : good_hdr(),
           rnd64());
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
